barramento_arbitro: RTL and testbench

Round-robin arbiter and sequencer for the processor's 6-port shared bus (Barramento). The six units, port 0 to port 5, are pilha, memoria, temp1, temp2, ula and uc.
- Each unit posts a transfer request naming a destination port.
- The block grants one request at a time and drives the bus's 2-bit per-port controls (bit 1 = write onto bus, bit 0 = read from bus).
- The read strobe is timed to match the bus's internal register pipeline, and the block signals completion to the requester.

---
 rtl/barramento_arbitro.sv | 179 +++++++++++++++++
 tb/tb_barramento_arbitro.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barramento_arbitro.sv
// barramento_arbitro
// Round-robin arbiter and sequencer for the 6-port shared bus (Barramento).
// Ports 0..5 are pilha, memoria, temp1, temp2, ula and uc. Each unit raises
// req[i] with its destination in dst_i. One request is granted at a time.
// The source drives the bus for one cycle. After LATENCIA edges the
// destination reads the bus, and done is pulsed to the requester.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req[5:0]       level request; port i is the source of its transfer
//   dst_0..dst_5   destination of each requester (0..5 legal, 6..7 illegal)
//   ctrl_0..ctrl_5 per-port bus controls: 10 = drive, 01 = read, 00 = idle
//   gnt[5:0]       one-hot, high while the granted source drives the bus
//   done[5:0]      one-hot 1-cycle pulse, transfer of port i completed
//   err[5:0]       one-hot 1-cycle pulse, request of port i had an illegal dst
//   busy           high whenever the sequencer is not idle
module barramento_arbitro #(
  parameter int LATENCIA = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  input  logic [2:0] dst_0,
  input  logic [2:0] dst_1,
  input  logic [2:0] dst_2,
  input  logic [2:0] dst_3,
  input  logic [2:0] dst_4,
  input  logic [2:0] dst_5,
  output logic [1:0] ctrl_0,
  output logic [1:0] ctrl_1,
  output logic [1:0] ctrl_2,
  output logic [1:0] ctrl_3,
  output logic [1:0] ctrl_4,
  output logic [1:0] ctrl_5,
  output logic [5:0] gnt,
  output logic [5:0] done,
  output logic [5:0] err,
  output logic       busy
);

  typedef enum logic [2:0] {
    OCIOSO,
    ESCRITA,
    ESPERA,
    LEITURA,
    ERRO
  } estado_t;

  // Wait-counter load value: ESPERA runs while cnt counts down to 1.
  localparam logic [1:0] CNT_INIT = 2'(LATENCIA - 1);

  estado_t         state_reg;
  logic [2:0]      src_reg;
  logic [2:0]      dst_reg;
  logic [2:0]      ptr_reg;
  logic [1:0]      cnt_reg;
  logic [5:0][1:0] ctrl_reg;
  logic [5:0]      gnt_reg;
  logic [5:0]      done_reg;
  logic [5:0]      err_reg;
  logic            busy_reg;

  logic [2:0]      dst_arr [6];
  logic            found;
  logic [2:0]      win;
  logic [3:0]      scan;

  assign dst_arr[0] = dst_0;
  assign dst_arr[1] = dst_1;
  assign dst_arr[2] = dst_2;
  assign dst_arr[3] = dst_3;
  assign dst_arr[4] = dst_4;
  assign dst_arr[5] = dst_5;

  // Rotating priority scan: start at ptr and wrap modulo 6. The first set
  // request bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int k = 0; k < 6; k++) begin
      scan = {1'b0, ptr_reg} + 4'(k);
      if (scan >= 4'd6) begin
        scan = scan - 4'd6;
      end
      if (!found && req[scan[2:0]]) begin
        found = 1'b1;
        win   = scan[2:0];
      end
    end
  end

  // Outputs are registered together with the state. They are set on the
  // edge that enters the state they belong to, so every output is a pure
  // function of the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= OCIOSO;
      src_reg   <= '0;
      dst_reg   <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      ctrl_reg  <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      err_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      ctrl_reg <= '0;
      gnt_reg  <= '0;
      done_reg <= '0;
      err_reg  <= '0;
      case (state_reg)
        OCIOSO: begin
          if (found) begin
            src_reg  <= win;
            ptr_reg  <= (win == 3'd5) ? 3'd0 : win + 3'd1;
            busy_reg <= 1'b1;
            if (dst_arr[win] <= 3'd5) begin
              dst_reg       <= dst_arr[win];
              state_reg     <= ESCRITA;
              gnt_reg[win]  <= 1'b1;
              ctrl_reg[win] <= 2'b10;
            end else begin
              state_reg    <= ERRO;
              err_reg[win] <= 1'b1;
            end
          end else begin
            busy_reg <= 1'b0;
          end
        end
        ESCRITA: begin
          cnt_reg <= CNT_INIT;
          if (LATENCIA == 1) begin
            state_reg         <= LEITURA;
            ctrl_reg[dst_reg] <= 2'b01;
            done_reg[src_reg] <= 1'b1;
          end else begin
            state_reg <= ESPERA;
          end
        end
        ESPERA: begin
          if (cnt_reg <= 2'd1) begin
            state_reg         <= LEITURA;
            ctrl_reg[dst_reg] <= 2'b01;
            done_reg[src_reg] <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        LEITURA: begin
          state_reg <= OCIOSO;
          busy_reg  <= 1'b0;
        end
        ERRO: begin
          state_reg <= OCIOSO;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= OCIOSO;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_0 = ctrl_reg[0];
  assign ctrl_1 = ctrl_reg[1];
  assign ctrl_2 = ctrl_reg[2];
  assign ctrl_3 = ctrl_reg[3];
  assign ctrl_4 = ctrl_reg[4];
  assign ctrl_5 = ctrl_reg[5];
  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign err    = err_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_barramento_arbitro.sv
// Bench for barramento_arbitro. Three instances run with LATENCIA = 2, 1
// and 3, and only one of them is exercised at a time. Stimulus pushes the
// expected gnt/done/err events into a queue. A negedge monitor pops one
// entry each time a DUT shows an event. It compares the port, the full
// ctrl pattern and the gnt-to-done spacing against that entry.
module tb_barramento_arbitro;

  localparam int K_GNT  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int inst;
    int kind;
    int port;
    int peer;
    int gap;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [17:0] req_all;
  logic [53:0] dst_all;
  logic [35:0] ctrl_all;
  logic [17:0] gnt_all;
  logic [17:0] done_all;
  logic [17:0] err_all;
  logic [2:0]  busy_all;

  ev_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_gnt [3];
  int  rem [6];
  int  bc;
  int  n;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      barramento_arbitro #(.LATENCIA(gi == 0 ? 2 : (gi == 1 ? 1 : 3))) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_all[gi*6 +: 6]),
        .dst_0  (dst_all[(gi*6+0)*3 +: 3]),
        .dst_1  (dst_all[(gi*6+1)*3 +: 3]),
        .dst_2  (dst_all[(gi*6+2)*3 +: 3]),
        .dst_3  (dst_all[(gi*6+3)*3 +: 3]),
        .dst_4  (dst_all[(gi*6+4)*3 +: 3]),
        .dst_5  (dst_all[(gi*6+5)*3 +: 3]),
        .ctrl_0 (ctrl_all[(gi*6+0)*2 +: 2]),
        .ctrl_1 (ctrl_all[(gi*6+1)*2 +: 2]),
        .ctrl_2 (ctrl_all[(gi*6+2)*2 +: 2]),
        .ctrl_3 (ctrl_all[(gi*6+3)*2 +: 2]),
        .ctrl_4 (ctrl_all[(gi*6+4)*2 +: 2]),
        .ctrl_5 (ctrl_all[(gi*6+5)*2 +: 2]),
        .gnt    (gnt_all[gi*6 +: 6]),
        .done   (done_all[gi*6 +: 6]),
        .err    (err_all[gi*6 +: 6]),
        .busy   (busy_all[gi])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  logic [5:0]  m_g, m_d, m_e, m_vec, m_exp_vec;
  logic [11:0] m_c, m_exp_c;
  int          m_nev, m_kind, m_gap;
  bit          m_gap_ok;
  ev_t         m_ev;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_g   = gnt_all[i*6 +: 6];
        m_d   = done_all[i*6 +: 6];
        m_e   = err_all[i*6 +: 6];
        m_c   = ctrl_all[i*12 +: 12];
        m_nev = int'(m_g != 0) + int'(m_d != 0) + int'(m_e != 0);
        n_assert++;
        if (m_nev == 0) begin
          if (m_c != 12'd0) begin
            n_fail++;
            $display("FAIL idle_ctrl inst%0d cyc%0d: ctrl=%b, expected all 00", i, cyc, m_c);
          end
        end else begin
          m_kind = (m_g != 0) ? K_GNT : ((m_d != 0) ? K_DONE : K_ERR);
          m_vec  = m_g | m_d | m_e;
          m_gap  = cyc - last_gnt[i];
          if (m_kind == K_GNT) last_gnt[i] = cyc;
          if (m_nev > 1) begin
            n_fail++;
            $display("FAIL multi_event inst%0d cyc%0d: gnt=%b done=%b err=%b, expected one kind", i, cyc, m_g, m_d, m_e);
          end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected inst%0d cyc%0d: kind=%0d vec=%b, expected no event", i, cyc, m_kind, m_vec);
          end else begin
            m_ev      = exp_q.pop_front();
            m_exp_vec = 6'b000001 << m_ev.port;
            case (m_ev.kind)
              K_GNT:   m_exp_c = 12'b10 << (2 * m_ev.port);
              K_DONE:  m_exp_c = 12'b01 << (2 * m_ev.peer);
              default: m_exp_c = 12'd0;
            endcase
            m_gap_ok = (m_ev.gap < 0) || (m_ev.gap == m_gap);
            if (m_ev.inst != i || m_ev.kind != m_kind || m_vec != m_exp_vec ||
                m_c != m_exp_c || !m_gap_ok) begin
              n_fail++;
              $display("FAIL event inst%0d cyc%0d: got kind=%0d vec=%b ctrl=%b gap=%0d, expected inst%0d kind=%0d vec=%b ctrl=%b gap=%0d",
                       i, cyc, m_kind, m_vec, m_c, m_gap,
                       m_ev.inst, m_ev.kind, m_exp_vec, m_exp_c, m_ev.gap);
            end
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int expv);
    n_assert++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_idle(input string name);
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (ctrl_all[i*12 +: 12] != 0 || gnt_all[i*6 +: 6] != 0 || done_all[i*6 +: 6] != 0 ||
          err_all[i*6 +: 6] != 0 || busy_all[i] != 1'b0) begin
        n_fail++;
        $display("FAIL %s inst%0d: ctrl=%b gnt=%b done=%b err=%b busy=%b, expected all zero",
                 name, i, ctrl_all[i*12 +: 12], gnt_all[i*6 +: 6], done_all[i*6 +: 6],
                 err_all[i*6 +: 6], busy_all[i]);
      end
    end
  endtask

  task automatic set_dst(input int inst, input int p, input int v);
    dst_all[(inst*6+p)*3 +: 3] = 3'(v);
  endtask

  task automatic push(input int inst, input int kind, input int port, input int peer, input int gap);
    ev_t e;
    e.inst = inst; e.kind = kind; e.port = port; e.peer = peer; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic xfer(input int inst, input int s, input int d, input int lat);
    push(inst, K_GNT, s, 0, -1);
    push(inst, K_DONE, s, d, lat);
  endtask

  task automatic clr_rem();
    for (int p = 0; p < 6; p++) rem[p] = 0;
  endtask

  // Requester model: raise every port with rem>0, drop req in the cycle
  // that shows done/err, and re-raise one cycle later while more remain.
  task automatic serve(input string name, input int inst, input int budget, output int busy_cyc);
    bit pend [6];
    int left;
    int k;
    busy_cyc = 0;
    k = 0;
    for (int p = 0; p < 6; p++) begin
      pend[p] = 1'b0;
      if (rem[p] > 0) req_all[inst*6+p] = 1'b1;
    end
    left = 0;
    for (int p = 0; p < 6; p++) left += rem[p];
    while (left > 0 && k < budget) begin
      @(negedge clk);
      k++;
      if (busy_all[inst]) busy_cyc++;
      for (int p = 0; p < 6; p++) begin
        if (pend[p]) begin
          req_all[inst*6+p] = 1'b1;
          pend[p] = 1'b0;
        end
      end
      for (int p = 0; p < 6; p++) begin
        if (done_all[inst*6+p] || err_all[inst*6+p]) begin
          req_all[inst*6+p] = 1'b0;
          if (rem[p] > 0) rem[p]--;
          if (rem[p] > 0) pend[p] = 1'b1;
        end
      end
      left = 0;
      for (int p = 0; p < 6; p++) left += rem[p];
    end
    req_all[inst*6 +: 6] = 6'd0;
    chk({name, "_remaining"}, left, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    req_all  = '0;
    dst_all  = '0;
    for (int i = 0; i < 3; i++) last_gnt[i] = 0;
    clr_rem();

    repeat (2) @(negedge clk);
    #2;
    check_idle("reset_init");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", int'(busy_all), 0);
    end

    // single transfer 4 -> 2, LATENCIA=2
    clr_rem();
    set_dst(0, 4, 2);
    rem[4] = 1;
    xfer(0, 4, 2, 2);
    serve("single", 0, 30, bc);
    chk("single_busy_cycles", bc, 3);

    // round robin 0 and 3, re-raised after each done (ptr starts at 5)
    clr_rem();
    set_dst(0, 0, 3);
    set_dst(0, 3, 0);
    rem[0] = 2;
    rem[3] = 2;
    xfer(0, 0, 3, 2);
    xfer(0, 3, 0, 2);
    xfer(0, 0, 3, 2);
    xfer(0, 3, 0, 2);
    serve("rr_0_3", 0, 60, bc);
    chk("rr_0_3_busy_cycles", bc, 12);

    // all six requesting with ptr=4: order 4,5,0,1,2,3 (3 writes to itself)
    clr_rem();
    set_dst(0, 0, 1);
    set_dst(0, 1, 2);
    set_dst(0, 2, 0);
    set_dst(0, 3, 3);
    set_dst(0, 4, 5);
    set_dst(0, 5, 4);
    for (int p = 0; p < 6; p++) rem[p] = 1;
    xfer(0, 4, 5, 2);
    xfer(0, 5, 4, 2);
    xfer(0, 0, 1, 2);
    xfer(0, 1, 2, 2);
    xfer(0, 2, 0, 2);
    xfer(0, 3, 3, 2);
    serve("rr_all", 0, 80, bc);

    // illegal dst 7 on port 1 (ptr=4 reaches 1 first), then pending port 2
    clr_rem();
    set_dst(0, 1, 7);
    set_dst(0, 2, 4);
    rem[1] = 1;
    rem[2] = 1;
    push(0, K_ERR, 1, 0, -1);
    xfer(0, 2, 4, 2);
    serve("illegal7", 0, 30, bc);
    chk("illegal7_busy_cycles", bc, 4);

    // boundary illegal dst 6 on port 0
    clr_rem();
    set_dst(0, 0, 6);
    rem[0] = 1;
    push(0, K_ERR, 0, 0, -1);
    serve("illegal6", 0, 20, bc);
    chk("illegal6_busy_cycles", bc, 1);

    // reset during ESPERA of a 5 -> 0 transfer
    set_dst(0, 5, 0);
    push(0, K_GNT, 5, 0, -1);
    req_all[5] = 1'b1;
    n = 0;
    while (!gnt_all[5] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("midop_gnt_seen", int'(gnt_all[5]), 1);
    @(negedge clk);
    chk("midop_espera_busy", int'(busy_all[0]), 1);
    #2;
    rst_n = 1'b0;
    req_all[5] = 1'b0;
    #1;
    check_idle("reset_midop");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midop_no_done", int'(done_all[5:0]), 0);
    end

    // after reset ptr=0, so port 0 wins over port 4
    clr_rem();
    set_dst(0, 0, 2);
    set_dst(0, 4, 1);
    rem[0] = 1;
    rem[4] = 1;
    xfer(0, 0, 2, 2);
    xfer(0, 4, 1, 2);
    serve("post_reset", 0, 30, bc);

    // LATENCIA=1: strobe gap 1, busy 2 cycles
    clr_rem();
    set_dst(1, 1, 5);
    rem[1] = 1;
    xfer(1, 1, 5, 1);
    serve("lat1_single", 1, 20, bc);
    chk("lat1_busy_cycles", bc, 2);

    clr_rem();
    set_dst(1, 0, 3);
    set_dst(1, 5, 0);
    rem[0] = 1;
    rem[5] = 1;
    xfer(1, 5, 0, 1);
    xfer(1, 0, 3, 1);
    serve("lat1_pair", 1, 30, bc);

    // LATENCIA=3: strobe gap 3, busy 4 cycles, src == dst
    clr_rem();
    set_dst(2, 3, 3);
    rem[3] = 1;
    xfer(2, 3, 3, 3);
    serve("lat3_single", 2, 30, bc);
    chk("lat3_busy_cycles", bc, 4);

    clr_rem();
    set_dst(2, 4, 6);
    rem[4] = 1;
    push(2, K_ERR, 4, 0, -1);
    serve("lat3_illegal", 2, 20, bc);
    chk("lat3_illegal_busy_cycles", bc, 1);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
